truth_table_sweeper: RTL and testbench
======================================

# truth_table_sweeper

- Sequential stimulus generator and response checker for small combinational equation circuits.
- Steps an N-input vector exhaustively from all-zeros to all-ones, holds each vector for a programmable settle time, and samples the circuit's single output.
- Compares the captured truth table against an expected table and reports the error count, the first failing vector, and pass/fail.
- Sits on the driving side of an equation circuit: it replaces hand-written timed stimulus and can be used both on-chip and in benches.

## Interface

Parameters:
- N_IN, default 3: number of circuit inputs; legal range 1..6.
- SETTLE, default 2: cycles each vector is held before its sample edge; legal range ≥1.

Ports (clock and reset are fixed: one clock; reset is asynchronous and active-low):
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  run request; honoured only in IDLE.
- expected  in  2**N_IN  expected table; bit i = required Y for vector i. Latched at start acceptance.
- stim  out  N_IN  applied vector; MSB is input A. Drives the circuit inputs.
- resp  in  1  circuit output Y.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse at sweep end.
- pass  out  1  1 when the last sweep had zero mismatches; held until the next accepted start.
- captured  out  2**N_IN  sampled Y per vector.
- err_count  out  N_IN+1  number of mismatching vectors; holds up to 2**N_IN.
- first_err  out  N_IN  index of the first mismatching vector.
- first_err_valid  out  1  high when at least one mismatch has been recorded.

## Operation

- States:
  - IDLE.
  - RUN: vector index plus settle counter.
  - DONE: exactly one cycle, then returns to IDLE.
- IDLE → RUN: on an edge with start=1. At that edge:
  - expected is latched.
  - captured, err_count, first_err, first_err_valid and pass are cleared.
  - Vector index and settle counter are set to 0.
- RUN:
  - stim = vector index.
  - Each vector occupies SETTLE+1 cycles.
  - On the last edge of a vector's slot, resp is written to captured[idx] and compared with latched expected[idx].
  - On a mismatch, err_count increments. If first_err_valid=0, first_err=idx and first_err_valid is set.
- After the sample edge of vector 2**N_IN−1 → DONE. Index wrap is never used to restart.
- DONE:
  - done=1 and busy=0; stim returns to 0.
  - pass is registered as (err_count==0), including the final vector's result.
- DONE → IDLE unconditionally. A start seen in the DONE cycle is ignored.
- start while busy: ignored, with no restart and no effect.
- Changes to expected during RUN: no effect (latched copy is used).
- Reset value of every output: stim=0, busy=0, done=0, pass=0, captured=0, err_count=0, first_err=0, first_err_valid=0.
- Reset mid-sweep returns immediately to IDLE with those values. No done pulse is emitted for the aborted sweep.

## Timing

- Let E0 be the edge that accepts start.
- busy rises after E0.
- Vector i is driven on stim from E0+i·(SETTLE+1) until E0+(i+1)·(SETTLE+1).
- resp is sampled at edge E0+(i+1)·(SETTLE+1), using its value from the preceding cycle.
- done pulses in the cycle after edge E0+2**N_IN·(SETTLE+1). With defaults, that is after E0+24.
- Results (pass, captured, err_count, first_err) are valid together with done and stable until the next accepted start.
- Earliest restart: start high in the IDLE cycle after DONE is accepted at that cycle's edge. Held-high start therefore gives back-to-back sweeps with a 2-cycle gap (DONE + IDLE).
- No combinational path from resp or start to any output; all outputs are registered.

## Test plan

- **Reset:** assert rst_n=0 mid-cycle.
  - All outputs go to reset values asynchronously; stim=0.
- **Golden circuit:** defaults; bench model Y=A|(B&C) (the POS equation (A+B+C)(A+B)(A+C)); expected=8'hF8; pulse start.
  - stim steps 0..7, holding each vector for 3 cycles.
  - done pulses after edge E0+24, with pass=1, captured=8'hF8, err_count=0, first_err_valid=0.
- **Stuck-at-0 output:** resp tied 0, expected=8'hF8.
  - captured=8'h00, err_count=5, first_err=3, first_err_valid=1, pass=0.
- **Wrong expectation:** golden model, expected=8'hFE.
  - err_count=2, first_err=1, captured=8'hF8, pass=0.
- **Start while busy, then reset mid-sweep:** start re-pulsed at E0+10; rst_n low at E0+12.
  - The second start is ignored (stim keeps stepping).
  - The reset returns everything to reset values and no done pulse occurs.
  - A new start afterwards completes normally with pass=1.
- **start held high continuously:** golden model.
  - Sweeps repeat; the second E0 is 2 cycles after the first done.
  - Results are cleared at each acceptance, and pass/captured match the golden run every time.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: steps every input vector, samples the circuit output and scores it against an expected table.
module truth_table_sweeper #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   expected,
    output logic [N_IN-1:0]      stim,
    input  logic                 resp,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2**N_IN-1:0]   captured,
    output logic [N_IN:0]        err_count,
    output logic [N_IN-1:0]      first_err,
    output logic                 first_err_valid
);
    localparam int T  = 2**N_IN;
    localparam int CW = $clog2(SETTLE + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t          state_q;
    logic [T-1:0]    exp_q, captured_q;
    logic [CW-1:0]   cnt_q;
    logic [N_IN-1:0] stim_q, first_q;
    logic [N_IN:0]   err_q, err_d;
    logic            busy_q, done_q, pass_q, fev_q, mis;
    assign mis   = resp != exp_q[stim_q];
    assign err_d = err_q + (N_IN+1)'(mis);
    assign stim            = stim_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign captured        = captured_q;
    assign err_count       = err_q;
    assign first_err       = first_q;
    assign first_err_valid = fev_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            exp_q      <= '0;
            captured_q <= '0;
            cnt_q      <= '0;
            stim_q     <= '0;
            first_q    <= '0;
            err_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fev_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_q    <= RUN;
                    exp_q      <= expected;
                    captured_q <= '0;
                    cnt_q      <= '0;
                    stim_q     <= '0;
                    first_q    <= '0;
                    err_q      <= '0;
                    busy_q     <= 1'b1;
                    pass_q     <= 1'b0;
                    fev_q      <= 1'b0;
                end
                RUN: if (cnt_q != CW'(SETTLE)) begin
                    cnt_q <= cnt_q + 1'b1;
                end else begin
                    // last edge of the slot: sample, score, then advance or finish
                    cnt_q              <= '0;
                    captured_q[stim_q] <= resp;
                    err_q              <= err_d;
                    if (mis && !fev_q) begin
                        first_q <= stim_q;
                        fev_q   <= 1'b1;
                    end
                    if (&stim_q) begin
                        state_q <= DONE;
                        stim_q  <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= err_d == '0;
                    end else begin
                        stim_q <= stim_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: scoreboard bench; a cycle-level timing model and a per-sweep result model drive the checks.
module tb_truth_table_sweeper;
    localparam int N = 3, S = 2, T = 8, L = T * (S + 1);
    logic clk = 0, rst_n = 0, start = 0, resp;
    logic [T-1:0] expected = '0, rtab = '0, captured;
    logic [N-1:0] stim, first_err;
    logic [N:0]   err_count;
    logic busy, done, pass, first_err_valid;
    int mode = 0;
    int checks = 0, errors = 0;
    typedef struct {
        logic [T-1:0] cap;
        int           errs;
        int           first;
        logic         pass;
    } res_t;
    res_t q[$];
    res_t last = '{'0, 0, 0, 1'b0};
    int cyc = 0, e0 = 0, next_ok = 0;
    bit have_e0 = 0;

    always #5 clk = ~clk;

    truth_table_sweeper #(.N_IN(N), .SETTLE(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .expected(expected), .stim(stim),
        .resp(resp), .busy(busy), .done(done), .pass(pass), .captured(captured),
        .err_count(err_count), .first_err(first_err), .first_err_valid(first_err_valid)
    );

    // mode 0: Y = A | (B & C) with A = MSB; mode 1: stuck-at-0; mode 2: arbitrary table
    function automatic logic circ(int m, logic [T-1:0] tab, logic [N-1:0] v);
        return m == 0 ? (v[2] | (v[1] & v[0])) : m == 1 ? 1'b0 : tab[v];
    endfunction

    always_comb resp = circ(mode, rtab, stim);

    function automatic res_t predict(int m, logic [T-1:0] tab, logic [T-1:0] ex);
        res_t r;
        r.cap = '0;
        r.errs = 0;
        r.first = 0;
        for (int v = 0; v < T; v++) begin
            r.cap[v] = circ(m, tab, N'(v));
            if (r.cap[v] !== ex[v]) begin
                if (r.errs == 0) r.first = v;
                r.errs++;
            end
        end
        r.pass = r.errs == 0;
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_e0 = 0;
            next_ok = 0;
        end else begin
            cyc++;
            if (start && cyc >= next_ok) begin
                e0 = cyc;
                have_e0 = 1;
                next_ok = cyc + L + 2;
                q.push_back(predict(mode, rtab, expected));
            end
        end
    end

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            last = '{'0, 0, 0, 1'b0};
        end else begin
            res_t r;
            int k;
            k = cyc;
            if (have_e0 && k >= e0 && k < e0 + L) begin
                chk("run_busy", busy, 1);
                chk("run_stim", stim, (k - e0) / (S + 1));
                chk("run_done", done, 0);
                chk("run_pass", pass, 0);
            end else if (have_e0 && k == e0 + L) begin
                chk("done_pulse", done, 1);
                chk("done_busy", busy, 0);
                chk("done_stim", stim, 0);
                if (q.size() == 0) chk("scoreboard_empty", 1, 0);
                else begin
                    r = q.pop_front();
                    chk("captured", captured, r.cap);
                    chk("err_count", err_count, r.errs);
                    chk("first_err_valid", first_err_valid, r.errs > 0);
                    chk("first_err", first_err, r.first);
                    chk("pass", pass, r.pass);
                    last = r;
                end
            end else begin
                chk("idle_busy", busy, 0);
                chk("idle_done", done, 0);
                chk("idle_stim", stim, 0);
                chk("hold_pass", pass, last.pass);
                chk("hold_captured", captured, last.cap);
                chk("hold_err_count", err_count, last.errs);
                chk("hold_fev", first_err_valid, last.errs > 0);
                chk("hold_first_err", first_err, last.first);
            end
        end
    end

    task automatic wait_done();
        for (int i = 0; i < L + 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) return;
        end
        chk("done_timeout", 0, 1);
    endtask

    task automatic run(int m, logic [T-1:0] ex, logic [T-1:0] tab);
        @(negedge clk);
        #1 mode = m;
        expected = ex;
        rtab = tab;
        start = 1;
        @(negedge clk);
        #1 start = 0;
        expected = T'($urandom);
        wait_done();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1 rst_n = 1;
        repeat (3) @(negedge clk);
        run(0, 8'hF8, '0);
        run(1, 8'hF8, '0);
        run(0, 8'hFE, '0);
        // restart attempt while busy, then asynchronous abort
        @(negedge clk);
        #1 mode = 0;
        expected = 8'hF8;
        start = 1;
        @(posedge clk);
        @(negedge clk);
        #1 start = 0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        #1 start = 1;
        @(negedge clk);
        #1 start = 0;
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        chk("arst_busy_pre", busy, 0);
        chk("arst_stim", stim, 0);
        chk("arst_done", done, 0);
        chk("arst_pass", pass, 0);
        chk("arst_captured", captured, 0);
        chk("arst_err_count", err_count, 0);
        chk("arst_first_err", first_err, 0);
        chk("arst_fev", first_err_valid, 0);
        @(negedge clk);
        #1 rst_n = 1;
        repeat (40) @(negedge clk);
        run(0, 8'hF8, '0);
        // held start: back-to-back sweeps
        @(negedge clk);
        #1 mode = 0;
        expected = 8'hF8;
        start = 1;
        repeat (3) wait_done();
        #1 start = 0;
        for (int i = 0; i < 4; i++) run(2, T'($urandom), T'($urandom));
        repeat (5) @(negedge clk);
        chk("scoreboard_leftover", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
